// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath and its front-end sequencer.
package alu_pkg;

    localparam int unsigned NB_DATA_DEF   = 8;
    localparam int unsigned NB_OPCODE_DEF = 6;

    localparam logic [NB_OPCODE_DEF-1:0] OP_ADD = 6'h20;
    localparam logic [NB_OPCODE_DEF-1:0] OP_SUB = 6'h22;
    localparam logic [NB_OPCODE_DEF-1:0] OP_AND = 6'h24;
    localparam logic [NB_OPCODE_DEF-1:0] OP_OR  = 6'h25;
    localparam logic [NB_OPCODE_DEF-1:0] OP_XOR = 6'h26;
    localparam logic [NB_OPCODE_DEF-1:0] OP_SRA = 6'h03;
    localparam logic [NB_OPCODE_DEF-1:0] OP_SRL = 6'h02;
    localparam logic [NB_OPCODE_DEF-1:0] OP_NOR = 6'h27;

    typedef enum logic [2:0] {
        ST_LOAD_A   = 3'd0,
        ST_LOAD_B   = 3'd1,
        ST_LOAD_OPC = 3'd2,
        ST_EXEC     = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    function automatic logic is_valid_opcode(input logic [NB_OPCODE_DEF-1:0] i_opc);
        case (i_opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: is_valid_opcode = 1'b1;
            default:                        is_valid_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_btn_debounce.sv
// Button conditioning: 2-FF synchronizer, level debouncer and rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int unsigned          NB_CNT   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [NB_CNT-1:0]    CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

    logic              r_sync_1;
    logic              r_sync_2;
    logic [NB_CNT-1:0] r_cnt;
    logic              r_level;
    logic              r_level_d;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync_1 <= 1'b0;
            r_sync_2 <= 1'b0;
        end else begin
            r_sync_1 <= i_btn;
            r_sync_2 <= r_sync_1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing cycles.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync_2 == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_level <= r_sync_2;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // One-cycle registered pulse on each debounced rising edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_level_d <= 1'b0;
            o_pulse   <= 1'b0;
        end else begin
            r_level_d <= r_level;
            o_pulse   <= r_level & ~r_level_d;
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Basys3 ALU front-end: steps switches into operands/opcode, runs one
// execute cycle, then holds the ALU result for the LEDs.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned NB_DATA         = NB_DATA_DEF,
    parameter int unsigned NB_OPCODE       = NB_OPCODE_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NB_DATA-1:0]   i_sw,
    input  logic                 i_btn_load,
    input  logic                 i_btn_clear,
    output logic [NB_DATA-1:0]   o_op_1,
    output logic [NB_DATA-1:0]   o_op_2,
    output logic [NB_OPCODE-1:0] o_opcode,
    input  logic [NB_DATA-1:0]   i_alu_result,
    input  logic                 i_alu_carry,
    output logic [NB_DATA-1:0]   o_result,
    output logic                 o_carry,
    output logic                 o_result_valid,
    output logic                 o_error,
    output logic [2:0]           o_state
);

    logic                 w_load_pulse;
    logic                 w_clear_pulse;
    logic                 w_opc_ok;
    state_t               r_state;
    logic [NB_DATA-1:0]   r_op_1;
    logic [NB_DATA-1:0]   r_op_2;
    logic [NB_OPCODE-1:0] r_opcode;
    logic [NB_DATA-1:0]   r_result;
    logic                 r_carry;
    logic                 r_valid;
    logic                 r_error;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_load),
        .o_pulse (w_load_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_clear),
        .o_pulse (w_clear_pulse)
    );

    assign w_opc_ok = is_valid_opcode(NB_OPCODE_DEF'(r_opcode));

    // Sequencer: clear beats load; EXEC is a single fixed cycle that captures the ALU.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_clear_pulse) begin
            r_state  <= ST_LOAD_A;
            r_op_1   <= '0;
            r_op_2   <= '0;
            r_opcode <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD_A: begin
                    if (w_load_pulse) begin
                        r_op_1  <= i_sw;
                        r_state <= ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    if (w_load_pulse) begin
                        r_op_2  <= i_sw;
                        r_state <= ST_LOAD_OPC;
                    end
                end
                ST_LOAD_OPC: begin
                    if (w_load_pulse) begin
                        r_opcode <= i_sw[NB_OPCODE-1:0];
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result <= i_alu_result;
                    r_carry  <= i_alu_carry;
                    r_error  <= ~w_opc_ok;
                    r_valid  <= 1'b1;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    if (w_load_pulse) begin
                        r_op_1  <= i_sw;
                        r_valid <= 1'b0;
                        r_state <= ST_LOAD_B;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_LOAD_A;
                end
            endcase
        end
    end

    assign o_op_1         = r_op_1;
    assign o_op_2         = r_op_2;
    assign o_opcode       = r_opcode;
    assign o_result       = r_result;
    assign o_carry        = r_carry;
    assign o_result_valid = r_valid;
    assign o_error        = r_error;
    assign o_state        = r_state;

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Front-end sequencer for the ALU on the Basys3 board. A single load button steps the switch bank into operand 1, then operand 2, then the opcode. The block then holds the ALU inputs stable for one execute cycle, registers the ALU result and carry, and holds them for the LEDs. The top level instantiates alu_seq_ctrl and the combinational ALU side by side. A clear button aborts at any point.

Parameters:
NB_DATA, 8, operand/result width (matches the ALU)
NB_OPCODE, 6, opcode width (matches the ALU)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz; benches use 4)

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_sw  in  NB_DATA  switch bank; opcode taken from i_sw[NB_OPCODE-1:0]
i_btn_load  in  1  raw load button, asynchronous and bouncy
i_btn_clear  in  1  raw clear button, asynchronous and bouncy
o_op_1  out  NB_DATA  registered operand 1 to the ALU
o_op_2  out  NB_DATA  registered operand 2 to the ALU
o_opcode  out  NB_OPCODE  registered opcode to the ALU
i_alu_result  in  NB_DATA  ALU combinational result
i_alu_carry  in  1  ALU carry
o_result  out  NB_DATA  captured result, drives the LEDs
o_carry  out  1  captured carry
o_result_valid  out  1  high while in DONE
o_error  out  1  captured opcode was not in the valid set
o_state  out  3  current FSM state, for debug LEDs

Behaviour:
- Reset: all outputs 0; state LOAD_A (encoded 0); debounce counters 0; debounced levels 0.
- Button path, per button:
  - 2-FF synchronizer.
  - Debouncer: counter restarts whenever the synchronized level differs from the current debounced level. The debounced level flips only after DEBOUNCE_CYCLES consecutive cycles of difference.
  - Rising-edge detector on the debounced level produces a 1-cycle pulse.
  - Raw-press-to-pulse latency is 2 + DEBOUNCE_CYCLES + 1 cycles. A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- FSM states: LOAD_A=0, LOAD_B=1, LOAD_OPC=2, EXEC=3, DONE=4.
  - LOAD_A, load pulse: o_op_1 <= i_sw; go to LOAD_B.
  - LOAD_B, load pulse: o_op_2 <= i_sw; go to LOAD_OPC.
  - LOAD_OPC, load pulse: o_opcode <= i_sw[NB_OPCODE-1:0]; go to EXEC.
  - EXEC: lasts exactly 1 cycle and ignores the load pulse. On its closing edge: o_result <= i_alu_result; o_carry <= i_alu_carry; o_error <= (opcode not in {0x20,0x22,0x24,0x25,0x26,0x03,0x02,0x27}); go to DONE.
  - DONE: o_result_valid=1. A load pulse does o_op_1 <= i_sw and goes to LOAD_B (back-to-back operation).
- Result holding: o_result, o_carry and o_error hold their values until the next EXEC capture. o_result_valid drops the cycle the FSM leaves DONE.
- Clear pulse, any state: go to LOAD_A; o_op_1, o_op_2, o_opcode, o_result, o_carry, o_error, o_result_valid all cleared to 0.
- Clear and load pulse in the same cycle: clear wins and the load is discarded.
- Reset mid-operation (including in EXEC): returns to the full reset state at the next edge; no capture occurs.
- o_op_1, o_op_2 and o_opcode change only on load pulses or clear. The ALU inputs are therefore stable through EXEC.
- No arithmetic is performed here. Widths pass through unchanged; the signed interpretation belongs to the ALU.

Decomposition:
- Shared package alu_pkg: NB_DATA and NB_OPCODE defaults, the eight opcode localparams (ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, SRA 0x03, SRL 0x02, NOR 0x27), and the FSM state encodings. The ALU and this controller both use this package.
- One sub-module, btn_debounce: synchronizer, debounce counter and edge pulse. It is parameterised by DEBOUNCE_CYCLES, with the counter width derived as $clog2(DEBOUNCE_CYCLES+1). Instantiate it twice.

Test Plan:
Bench setup: DEBOUNCE_CYCLES=4, real ALU attached.
1. Sw=0x05 load, sw=0x03 load, sw=0x20 load -> EXEC for 1 cycle; then o_result=0x08, o_result_valid=1, o_error=0, o_state=4.
2. Operands 0x03, 0x05, opcode 0x22 -> o_result=0xFE. Then in DONE, load sw=0x80 -> o_op_1=0x80, state 1, valid=0, o_result still 0xFE.
3. Operands 0x80, 0x02, opcode 0x03 (SRA) -> o_result=0xE0. Repeat with opcode 0x02 (SRL) -> 0x20.
4. Operands 0x11, 0x22, opcode 0x3F -> o_result=0x00, o_error=1. The next valid operation clears o_error.
5. Load 0x05, then a 2-cycle glitch on i_btn_load -> no state change. Then clear held 5 cycles -> state 0, all outputs 0.
6. Clear and load raw presses aligned so their pulses coincide -> state 0, o_op_1 unchanged at 0. Separately, reset asserted during EXEC -> o_result stays 0, state 0.
